// File: rtl/ps2_key_tx_pkg.sv
// Shared constants for the PS/2 keystroke transmitter: scan codes, key-code width, FSM states.
package ps2_key_tx_pkg;

    localparam int KEY_W     = 6;
    localparam int BIT_LAST  = 10;
    localparam int BYTE_LAST = 2;

    localparam logic [7:0] SC_0     = 8'h70;
    localparam logic [7:0] SC_1     = 8'h69;
    localparam logic [7:0] SC_2     = 8'h72;
    localparam logic [7:0] SC_3     = 8'h7A;
    localparam logic [7:0] SC_4     = 8'h6B;
    localparam logic [7:0] SC_5     = 8'h73;
    localparam logic [7:0] SC_6     = 8'h74;
    localparam logic [7:0] SC_7     = 8'h6C;
    localparam logic [7:0] SC_8     = 8'h75;
    localparam logic [7:0] SC_9     = 8'h7D;
    localparam logic [7:0] SC_BREAK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_GAP
    } state_t;

endpackage

// File: rtl/ps2_key_tx_btos_enc.sv
// Key code to scan code encoder; the inverse of the scan-code decoder table.
module btos_enc
    import ps2_key_tx_pkg::*;
(
    input  logic [KEY_W-1:0] i_code,
    output logic [7:0]       o_scan,
    output logic             o_valid
);

    always_comb begin
        o_scan  = 8'h00;
        o_valid = 1'b1;
        case (i_code)
            6'd0:    o_scan = SC_0;
            6'd1:    o_scan = SC_1;
            6'd2:    o_scan = SC_2;
            6'd3:    o_scan = SC_3;
            6'd4:    o_scan = SC_4;
            6'd5:    o_scan = SC_5;
            6'd6:    o_scan = SC_6;
            6'd7:    o_scan = SC_7;
            6'd8:    o_scan = SC_8;
            6'd9:    o_scan = SC_9;
            default: o_valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 device-side transmitter: one accepted digit key becomes make, F0, make frames.
module ps2_key_tx
    import ps2_key_tx_pkg::*;
#(
    parameter int HALF_BIT = 4000,
    parameter int GAP_CYC  = 8000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] in_code,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             ps2_clk,
    output logic             ps2_data
);

    localparam int CNT_MAX = (HALF_BIT > GAP_CYC) ? HALF_BIT : GAP_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] HALF_TC = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] GAP_TC  = CW'(GAP_CYC - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bit;
    logic [1:0]    r_byte;
    logic [7:0]    r_scan;

    logic [7:0] w_scan;
    logic       w_scan_ok;
    logic [7:0] w_byte;
    logic       w_parity;
    logic [3:0] w_next_idx;
    logic [2:0] w_data_idx;
    logic       w_next_bit;
    logic       w_half_end;
    logic       w_gap_end;

    btos_enc u_enc (
        .i_code  (in_code),
        .o_scan  (w_scan),
        .o_valid (w_scan_ok)
    );

    // Middle frame of every keystroke is the break prefix.
    assign w_byte     = (r_byte == 2'd1) ? SC_BREAK : r_scan;
    assign w_parity   = ~^w_byte;
    assign w_next_idx = r_bit + 4'd1;
    assign w_data_idx = 3'(w_next_idx - 4'd1);
    assign w_half_end = (r_cnt == HALF_TC);
    assign w_gap_end  = (r_cnt == GAP_TC);

    always_comb begin
        w_next_bit = 1'b1;
        case (w_next_idx)
            4'd9:    w_next_bit = w_parity;
            4'd10:   w_next_bit = 1'b1;
            default: w_next_bit = w_byte[w_data_idx];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_bit    <= 4'd0;
            r_byte   <= 2'd0;
            r_scan   <= 8'h00;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        if (w_scan_ok) begin
                            // Start bit goes out immediately so it is visible the cycle after accept.
                            r_scan   <= w_scan;
                            r_state  <= ST_HIGH;
                            r_cnt    <= '0;
                            r_bit    <= 4'd0;
                            r_byte   <= 2'd0;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            ps2_data <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        r_state <= ST_LOW;
                        ps2_clk <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_LOW: begin
                    if (w_half_end) begin
                        r_cnt   <= '0;
                        ps2_clk <= 1'b1;
                        if (r_bit == 4'(BIT_LAST)) begin
                            r_state  <= ST_GAP;
                            ps2_data <= 1'b1;
                        end else begin
                            r_state  <= ST_HIGH;
                            r_bit    <= w_next_idx;
                            ps2_data <= w_next_bit;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (w_gap_end) begin
                        r_cnt <= '0;
                        r_bit <= 4'd0;
                        if (r_byte == 2'(BYTE_LAST)) begin
                            r_state  <= ST_IDLE;
                            r_byte   <= 2'd0;
                            done     <= 1'b1;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            r_state  <= ST_HIGH;
                            r_byte   <= r_byte + 2'd1;
                            ps2_data <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_key_tx.sv
// Scoreboard bench for ps2_key_tx: expected frames queued at accept, checked as bits fall on ps2_clk.
module tb_ps2_key_tx;

    localparam int HB  = 4;
    localparam int GC  = 8;
    localparam int KEY = 3 * (22 * HB + GC);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] in_code = 6'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, busy, done, err, ps2_clk, ps2_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cyc;

    logic [7:0] exp_q[$];
    logic       par_q[$];
    logic [7:0] sc_tab [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    ps2_key_tx #(.HALF_BIT(HB), .GAP_CYC(GC)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_code  (in_code),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Host-side receiver: samples data on falling ps2_clk and checks each completed frame.
    logic        prev_pclk = 1'b1;
    logic        prev_pdat = 1'b1;
    logic [10:0] fbits;
    int          nbits = 0;
    always @(negedge clk) begin
        if (rst) begin
            nbits = 0;
        end else begin
            if (!prev_pclk && !ps2_clk) begin
                total++;
                if (ps2_data !== prev_pdat) begin
                    bad++;
                    $display("FAIL data_stable_low: data %b was %b while ps2_clk low", ps2_data, prev_pdat);
                end
            end
            if (prev_pclk && !ps2_clk) begin
                fbits[nbits] = ps2_data;
                nbits++;
                if (nbits == 11) begin
                    nbits = 0;
                    total += 3;
                    if (fbits[0] !== 1'b0) begin
                        bad++; $display("FAIL start_bit: got %b want 0", fbits[0]);
                    end
                    if (fbits[10] !== 1'b1) begin
                        bad++; $display("FAIL stop_bit: got %b want 1", fbits[10]);
                    end
                    if ((^fbits[9:1]) !== 1'b1) begin
                        bad++; $display("FAIL odd_parity: byte %h parity %b", fbits[8:1], fbits[9]);
                    end
                    par_q.push_back(fbits[9]);
                    if (exp_q.size() == 0) begin
                        bad++; $display("FAIL unexpected_frame: got %h with nothing expected", fbits[8:1]);
                    end else begin
                        logic [7:0] want;
                        want = exp_q.pop_front();
                        if (fbits[8:1] !== want) begin
                            bad++; $display("FAIL frame_byte: got %h want %h", fbits[8:1], want);
                        end
                    end
                end
            end
        end
        prev_pclk = ps2_clk;
        prev_pdat = ps2_data;
    end

    task automatic push_key(input int k);
        exp_q.push_back(sc_tab[k]);
        exp_q.push_back(8'hF0);
        exp_q.push_back(sc_tab[k]);
    endtask

    task automatic start_key(input logic [5:0] code);
        @(posedge clk); #1;
        in_code  = code;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc_cyc  = cyc;
        if (code <= 6'd9) push_key(int'(code));
    endtask

    task automatic wait_done(input int budget, output int dcyc, output bit got);
        got  = 1'b0;
        dcyc = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done) begin
                got  = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        total += 6;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        if (err !== 1'b0)      begin bad++; $display("FAIL reset_err: got %b want 0", err); end
        if (ps2_clk !== 1'b1)  begin bad++; $display("FAIL reset_ps2_clk: got %b want 1", ps2_clk); end
        if (ps2_data !== 1'b1) begin bad++; $display("FAIL reset_ps2_data: got %b want 1", ps2_data); end
    endtask

    task automatic test_key(input logic [5:0] code, input logic [2:0] want_par);
        int d; bit got;
        par_q.delete();
        start_key(code);
        total += 3;
        if (busy !== 1'b1)     begin bad++; $display("FAIL key%0d_busy: got %b want 1", code, busy); end
        if (in_ready !== 1'b0) begin bad++; $display("FAIL key%0d_in_ready: got %b want 0", code, in_ready); end
        if (ps2_data !== 1'b0) begin bad++; $display("FAIL key%0d_start_bit: got %b want 0", code, ps2_data); end
        wait_done(KEY + 50, d, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL key%0d_done_timeout: no done within %0d cycles", code, KEY + 50);
        end else if (d - acc_cyc != KEY) begin
            bad++; $display("FAIL key%0d_latency: got %0d want %0d", code, d - acc_cyc, KEY);
        end
        total += 2;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL key%0d_ready_at_done: got %b want 1", code, in_ready); end
        @(posedge clk); #1;
        if (done !== 1'b0) begin bad++; $display("FAIL key%0d_done_pulse: got %b want 0", code, done); end
        total += 2;
        if (exp_q.size() != 0) begin bad++; $display("FAIL key%0d_frames_left: got %0d want 0", code, exp_q.size()); end
        if (par_q.size() != 3) begin
            bad++; $display("FAIL key%0d_parity_count: got %0d want 3", code, par_q.size());
        end else if ({par_q[0], par_q[1], par_q[2]} !== want_par) begin
            bad++; $display("FAIL key%0d_parity: got %b%b%b want %b", code, par_q[0], par_q[1], par_q[2], want_par);
        end
    endtask

    task automatic test_err();
        int viol = 0;
        start_key(6'd12);
        total += 3;
        if (err !== 1'b1)      begin bad++; $display("FAIL err_pulse: got %b want 1", err); end
        if (ps2_clk !== 1'b1)  begin bad++; $display("FAIL err_ps2_clk: got %b want 1", ps2_clk); end
        if (ps2_data !== 1'b1) begin bad++; $display("FAIL err_ps2_data: got %b want 1", ps2_data); end
        @(posedge clk); #1;
        total += 2;
        if (err !== 1'b0)      begin bad++; $display("FAIL err_width: got %b want 0", err); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL err_in_ready: got %b want 1", in_ready); end
        repeat (KEY + 20) begin
            @(posedge clk); #1;
            if (done || !ps2_clk || !ps2_data || busy) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL err_quiet: got %0d active cycles want 0", viol); end
    endtask

    task automatic test_reset_mid();
        int viol = 0;
        start_key(6'd5);
        while (cyc < acc_cyc + 39) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        total += 4;
        if (ps2_clk !== 1'b1)  begin bad++; $display("FAIL rstmid_ps2_clk: got %b want 1", ps2_clk); end
        if (ps2_data !== 1'b1) begin bad++; $display("FAIL rstmid_ps2_data: got %b want 1", ps2_data); end
        if (busy !== 1'b0)     begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        repeat (KEY + 20) begin
            @(posedge clk); #1;
            if (done || !ps2_clk || !ps2_data) viol++;
        end
        total++;
        if (viol != 0) begin bad++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", viol); end
        test_key(6'd3, 3'b010);
    endtask

    task automatic test_back_to_back();
        int d1, d2, acc2; bit got;
        @(posedge clk); #1;
        in_code  = 6'd1;
        in_valid = 1'b1;
        @(posedge clk); #1;
        acc_cyc = cyc;
        push_key(1);
        in_code = 6'd2;
        push_key(2);
        wait_done(KEY + 50, d1, got);
        total += 2;
        if (!got) begin
            bad++; $display("FAIL b2b_first_timeout: no done within %0d cycles", KEY + 50);
        end else if (d1 - acc_cyc != KEY) begin
            bad++; $display("FAIL b2b_first_latency: got %0d want %0d", d1 - acc_cyc, KEY);
        end
        if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_done: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        acc2 = cyc;
        total += 2;
        if (busy !== 1'b1)     begin bad++; $display("FAIL b2b_accept_busy: got %b want 1", busy); end
        if (ps2_data !== 1'b0) begin bad++; $display("FAIL b2b_accept_start: got %b want 0", ps2_data); end
        wait_done(KEY + 50, d2, got);
        total++;
        if (!got) begin
            bad++; $display("FAIL b2b_second_timeout: no done within %0d cycles", KEY + 50);
        end else if (d2 - acc2 != KEY) begin
            bad++; $display("FAIL b2b_second_latency: got %0d want %0d", d2 - acc2, KEY);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_frames_left: got %0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_key(6'd0, 3'b010);
        test_key(6'd9, 3'b111);
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
